// File: rtl/game1_seg_display.sv
// Scan-multiplexed 8-digit seven-segment driver for the one-player button game.
// Inputs are registered once, then rendered per scanned digit with blink masking.
module game1_seg_display #(
  parameter int SCAN_DIV   = 1,
  parameter int BLINK_HALF = 500
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] state_game_i,
  input  logic [2:0] state3_i,
  input  logic [3:0] level_i,
  input  logic [3:0] count_down_i,
  input  logic [3:0] g10_i,
  input  logic [3:0] g1_i,
  input  logic [3:0] p10_i,
  input  logic [3:0] p1_i,
  output logic [7:0] seg_com_o,
  output logic [7:0] seg_data_o,
  output logic [2:0] screen_o
);

  typedef enum logic [2:0] {
    SCR_OFF   = 3'd0,
    SCR_READY = 3'd1,
    SCR_PLAY  = 3'd2,
    SCR_FAIL  = 3'd3,
    SCR_ALL   = 3'd4
  } screen_e;

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(2 * BLINK_HALF);
  localparam logic [DW-1:0] DIV_MAX   = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(2 * BLINK_HALF - 1);
  localparam logic [BW-1:0] BLINK_LIM = BW'(BLINK_HALF);

  screen_e       screen_q, screen_d;
  logic [3:0]    level_q, cd_q, g10_q, g1_q, p10_q, p1_q;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [7:0]    com_q, com_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    glyph;
  logic          blink_en;

  function automatic logic [7:0] num_glyph(input logic [3:0] v);
    case (v)
      4'd0: num_glyph = 8'h3F;
      4'd1: num_glyph = 8'h06;
      4'd2: num_glyph = 8'h5B;
      4'd3: num_glyph = 8'h4F;
      4'd4: num_glyph = 8'h66;
      4'd5: num_glyph = 8'h6D;
      4'd6: num_glyph = 8'h7D;
      4'd7: num_glyph = 8'h07;
      4'd8: num_glyph = 8'h7F;
      4'd9: num_glyph = 8'h6F;
      default: num_glyph = 8'h40;
    endcase
  endfunction

  always_comb begin
    screen_d = SCR_OFF;
    if (state_game_i == 4'b0110) begin
      if (state3_i[2])      screen_d = SCR_ALL;
      else if (state3_i[1]) screen_d = SCR_FAIL;
      else if (state3_i[0]) screen_d = SCR_READY;
      else                  screen_d = SCR_PLAY;
    end
  end

  // Scan counters free-run; only a screen change touches the blink counter.
  always_comb begin
    div_d   = (div_q == DIV_MAX) ? '0 : div_q + DW'(1);
    idx_d   = (div_q == DIV_MAX) ? idx_q + 3'd1 : idx_q;
    blink_d = (blink_q == BLINK_MAX) ? '0 : blink_q + BW'(1);
    if (screen_d != screen_q) blink_d = '0;
  end

  always_comb begin
    glyph    = 8'h00;
    blink_en = 1'b0;
    case (screen_q)
      SCR_READY: begin
        blink_en = 1'b1;
        case (idx_q)
          3'd7: glyph = 8'h50;
          3'd6: glyph = 8'h79;
          3'd5: glyph = 8'h77;
          3'd4: glyph = 8'h5E;
          3'd3: glyph = 8'h6E;
          3'd1: glyph = 8'h38;
          3'd0: glyph = num_glyph(level_q);
          default: glyph = 8'h00;
        endcase
      end
      SCR_PLAY: begin
        case (idx_q)
          3'd7: glyph = 8'h38;
          3'd6: glyph = num_glyph(level_q);
          3'd4: begin
            glyph    = num_glyph(cd_q);
            blink_en = (cd_q <= 4'd1);
          end
          3'd3: glyph = (g10_q == 4'd0) ? 8'h00 : num_glyph(g10_q);
          3'd2: glyph = num_glyph(g1_q) | 8'h80;
          3'd1: glyph = (p10_q == 4'd0) ? 8'h00 : num_glyph(p10_q);
          3'd0: glyph = num_glyph(p1_q);
          default: glyph = 8'h00;
        endcase
      end
      SCR_FAIL: begin
        blink_en = 1'b1;
        case (idx_q)
          3'd7: glyph = 8'h71;
          3'd6: glyph = 8'h77;
          3'd5: glyph = 8'h30;
          3'd4: glyph = 8'h38;
          default: glyph = 8'h00;
        endcase
      end
      SCR_ALL: begin
        blink_en = 1'b1;
        case (idx_q)
          3'd7: glyph = 8'h77;
          3'd6: glyph = 8'h38;
          3'd5: glyph = 8'h38;
          3'd3: glyph = 8'h39;
          3'd2: glyph = 8'h38;
          3'd1: glyph = 8'h50;
          default: glyph = 8'h00;
        endcase
      end
      default: glyph = 8'h00;
    endcase
    com_d  = ~(8'b1 << idx_q);
    data_d = (blink_en && !(blink_q < BLINK_LIM)) ? 8'h00 : glyph;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      screen_q <= SCR_OFF;
      level_q  <= '0;
      cd_q     <= '0;
      g10_q    <= '0;
      g1_q     <= '0;
      p10_q    <= '0;
      p1_q     <= '0;
      div_q    <= '0;
      idx_q    <= '0;
      blink_q  <= '0;
      com_q    <= 8'hFF;
      data_q   <= 8'h00;
    end else begin
      screen_q <= screen_d;
      level_q  <= level_i;
      cd_q     <= count_down_i;
      g10_q    <= g10_i;
      g1_q     <= g1_i;
      p10_q    <= p10_i;
      p1_q     <= p1_i;
      div_q    <= div_d;
      idx_q    <= idx_d;
      blink_q  <= blink_d;
      com_q    <= com_d;
      data_q   <= data_d;
    end
  end

  assign seg_com_o  = com_q;
  assign seg_data_o = data_q;
  assign screen_o   = screen_q;

endmodule

// File: tb/tb_game1_seg_display.sv
// Directed bench for game1_seg_display: vector table of screens plus reset,
// countdown-blink and screen-priority/blink-restart sequences.
module tb_game1_seg_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sg, lv, cd, g10, g1, p10, p1;
  logic [2:0] st3;
  logic [7:0] seg_com, seg_data;
  logic [2:0] screen;

  game1_seg_display #(.SCAN_DIV(1), .BLINK_HALF(500)) dut (
    .clk_i(clk), .rst_i(rst), .state_game_i(sg), .state3_i(st3),
    .level_i(lv), .count_down_i(cd), .g10_i(g10), .g1_i(g1),
    .p10_i(p10), .p1_i(p1),
    .seg_com_o(seg_com), .seg_data_o(seg_data), .screen_o(screen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]      sg;
    logic [2:0]      st3;
    logic [3:0]      lv, cd, g10, g1, p10, p1;
    logic [2:0]      scr;
    logic [7:0][7:0] dig;   // dig[7] is the leftmost digit
  } vec_t;

  localparam int NV = 10;
  vec_t vt [NV];
  logic [7:0] cap [8];

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    sg = v.sg; st3 = v.st3; lv = v.lv; cd = v.cd;
    g10 = v.g10; g1 = v.g1; p10 = v.p10; p1 = v.p1;
  endtask

  // Eight consecutive scan slots; every slot must select exactly one digit.
  task automatic capture(input string name);
    for (int s = 0; s < 8; s++) begin
      int k;
      @(negedge clk);
      k = -1;
      for (int j = 0; j < 8; j++)
        if (seg_com === ~(8'b1 << j)) k = j;
      n_checks++;
      if (k < 0) begin
        n_fail++;
        $display("FAIL %s onehot: got seg_com %02h expected one low bit", name, seg_com);
      end else begin
        cap[k] = seg_data;
      end
    end
  endtask

  task automatic check_digits(input string name, input logic [7:0][7:0] exp);
    for (int d = 0; d < 8; d++) cap[d] = 8'hEE;
    capture(name);
    for (int d = 7; d >= 0; d--)
      chk8($sformatf("%s d%0d", name, d), cap[d], exp[d]);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Route through OFF first so each vector starts with a freshly cleared blink counter.
  task automatic apply_fresh(input vec_t v, output int t0);
    sg = 4'b0000;
    repeat (3) @(negedge clk);
    set_in(v);
    t0 = cyc;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vec_t v;
    int t0, t1, t2;
    logic [7:0] e;

    vt[0] = '{4'b0101, 3'b000, 4'd3, 4'd4, 4'd3, 4'd0, 4'd0, 4'd7, 3'd0, 64'h00_00_00_00_00_00_00_00};
    vt[1] = '{4'b0110, 3'b000, 4'd3, 4'd4, 4'd3, 4'd0, 4'd0, 4'd7, 3'd2, 64'h38_4F_00_66_4F_BF_00_07};
    vt[2] = '{4'b0110, 3'b000, 4'd6, 4'd9, 4'd1, 4'd5, 4'd2, 4'd0, 3'd2, 64'h38_7D_00_6F_06_ED_5B_3F};
    vt[3] = '{4'b0110, 3'b000, 4'd1, 4'd1, 4'd0, 4'd9, 4'd0, 4'd0, 3'd2, 64'h38_06_00_06_00_EF_00_3F};
    vt[4] = '{4'b0110, 3'b001, 4'd12, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 3'd1, 64'h50_79_77_5E_6E_00_38_40};
    vt[5] = '{4'b0110, 3'b001, 4'd2, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 3'd1, 64'h50_79_77_5E_6E_00_38_5B};
    vt[6] = '{4'b0110, 3'b010, 4'd2, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 3'd3, 64'h71_77_30_38_00_00_00_00};
    vt[7] = '{4'b0110, 3'b011, 4'd2, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 3'd3, 64'h71_77_30_38_00_00_00_00};
    vt[8] = '{4'b0110, 3'b101, 4'd2, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 3'd4, 64'h77_38_38_00_39_38_50_00};
    vt[9] = '{4'b0110, 3'b000, 4'd4, 4'd0, 4'd15, 4'd8, 4'd10, 4'd12, 3'd2, 64'h38_66_00_3F_40_FF_40_40};

    // Reset state and first scan steps
    rst = 1'b1;
    sg = 4'b0; st3 = 3'b0; lv = 4'd0; cd = 4'd0; g10 = 4'd0; g1 = 4'd0; p10 = 4'd0; p1 = 4'd0;
    #2;
    chk8("reset seg_com", seg_com, 8'hFF);
    chk8("reset seg_data", seg_data, 8'h00);
    chk8("reset screen", {5'b0, screen}, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    e = 8'hFE;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk8($sformatf("walk %0d", i), seg_com, e);
      e = {e[6:0], e[7]};
    end

    // Table of screens
    for (int i = 0; i < NV; i++) begin
      apply_fresh(vt[i], t0);
      chk8($sformatf("vec%0d screen", i), {5'b0, screen}, {5'b0, vt[i].scr});
      check_digits($sformatf("vec%0d", i), vt[i].dig);
    end

    // Countdown blink on digit 4 only
    v = vt[3];
    apply_fresh(v, t0);
    wait_until(t0 + 200);
    check_digits("cd on", 64'h38_06_00_06_00_EF_00_3F);
    wait_until(t0 + 700);
    check_digits("cd off", 64'h38_06_00_00_00_EF_00_3F);
    wait_until(t0 + 1200);
    check_digits("cd on2", 64'h38_06_00_06_00_EF_00_3F);

    // Priority and blink restart on screen change
    st3 = 3'b111;
    @(negedge clk);
    chk8("all screen", {5'b0, screen}, 8'h04);
    t1 = cyc;
    check_digits("all on", 64'h77_38_38_00_39_38_50_00);
    wait_until(t1 + 700);
    check_digits("all off", 64'h0);
    wait_until(t1 + 1200);
    check_digits("all on2", 64'h77_38_38_00_39_38_50_00);
    wait_until(t1 + 1300);
    st3 = 3'b010;
    @(negedge clk);
    chk8("fail screen", {5'b0, screen}, 8'h03);
    t2 = cyc;
    check_digits("fail on", 64'h71_77_30_38_00_00_00_00);
    wait_until(t2 + 420);
    check_digits("fail restart", 64'h71_77_30_38_00_00_00_00);
    wait_until(t2 + 700);
    check_digits("fail off", 64'h0);

    // Asynchronous reset mid-scan
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk8("midrst seg_com", seg_com, 8'hFF);
    chk8("midrst seg_data", seg_data, 8'h00);
    chk8("midrst screen", {5'b0, screen}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk8("midrst walk0", seg_com, 8'hFE);
    @(negedge clk);
    chk8("midrst walk1", seg_com, 8'hFD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game1_seg_display.md
# game1_seg_display

Scan-multiplexed 8-digit seven-segment driver for the one-player button game. It consumes the game block's status word (`STATE3`), `LEVEL`, the `COUNT_DOWN` seconds digit and the goal/press BCD digits, and it sits directly downstream of the game block. It selects one of five screens, renders each as fixed glyphs plus live digits, and handles blinking. It drives the common-anode digit selects and the segment lines of the board display.

## Interface
- `SCAN_DIV`, default 1: CLK cycles each digit stays selected (≥1).
- `BLINK_HALF`, default 500: CLK cycles per blink half-period (500 ms at the 1 kHz game clock).
- `CLK  in  1`: system clock, 1 kHz; the same clock as the game block.
- `RESET  in  1`: reset. One clock domain; reset is asynchronous and active-high.
- `STATE_GAME  in  4`: menu option; the display is active only when this equals 4'b0110.
- `STATE3  in  3`: {ALL_CLEAR, LEVEL_FAIL, LEVEL_CLEAR}.
- `LEVEL  in  4`: current level, 1..6.
- `COUNT_DOWN  in  4`: remaining seconds in the play window.
- `G10, G1, P10, P1  in  4 each`: goal tens/ones and press tens/ones (BCD).
- `SEG_COM  out  8`: digit select, active-low, one-hot-low; bit 0 is the rightmost digit.
- `SEG_DATA  out  8`: segments {dp,g,f,e,d,c,b,a}, active-high.
- `SCREEN  out  3`: current screen code, for verification. OFF=0, READY=1, PLAY=2, FAIL=3, ALL=4.

## Operation
Screen selection (combinational next-state, registered into `SCREEN` every cycle):
- `STATE_GAME != 0110` → OFF.
- Otherwise use the first match, in priority order:
  - `STATE3[2]` → ALL
  - `STATE3[1]` → FAIL
  - `STATE3[0]` → READY
  - none → PLAY
- Illegal multi-bit `STATE3` values resolve by this priority.

Digit map (digit 7 is leftmost):
- OFF: all digits blank (0x00); scanning continues.
- READY: digits 7..3 = "rEAdY"; digit 2 blank; digit 1 = 'L'; digit 0 = LEVEL. Whole screen blinks.
- PLAY:
  - Digit 7 = 'L', digit 6 = LEVEL, digit 5 blank, digit 4 = COUNT_DOWN.
  - Digits 3..0 = G10, G1, P10, P1.
  - dp lit on digit 2.
  - G10 and P10 are blanked when 0 (leading-zero suppression).
  - No screen blink. Digit 4 alone blinks while COUNT_DOWN ≤ 1.
- FAIL: digits 7..4 = "FAIL"; digits 3..0 blank. Whole screen blinks.
- ALL: digits 7..5 = "ALL"; digit 4 blank; digits 3..1 = "CLr"; digit 0 blank. Whole screen blinks.

Glyph codes:
- Numerals 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
- Any numeric input value 10–15 renders as dash 0x40.
- Letters: L=38, r=50, E=79, A=77, d=5E, Y=6E, F=71, I=30, C=39, blank=00.

Scan:
- 3-bit digit index plus a divider counter 0..SCAN_DIV-1.
- The index increments (wraps 7→0) when the divider reaches SCAN_DIV-1.
- `SEG_COM = ~(8'b1 << idx)`.

Blink:
- Counter 0..2·BLINK_HALF-1, free-running.
- Phase is ON for counts < BLINK_HALF.
- During OFF phase, blinking digits output 0x00 while `SEG_COM` keeps scanning.

## Timing
- Reset values: `SEG_COM` = 0xFF, `SEG_DATA` = 0x00, `SCREEN` = 0 (OFF). Digit index, divider and blink counter = 0; blink phase ON.
- Reset takes effect asynchronously; first scan step follows the first CLK edge after RESET falls.
- Pipeline:
  - Edge k: inputs are sampled into the `SCREEN` register and a registered copy of all data inputs.
  - Edge k+1: `SEG_COM` and `SEG_DATA` are updated together from the index and the registered data.
  - Input-to-pin latency is 2 cycles. `SEG_COM` and `SEG_DATA` are always mutually aligned.
- Screen change: on any cycle where next `SCREEN` differs from current, the blink counter clears to 0 (phase ON). Every new screen therefore appears immediately for a full BLINK_HALF.
- Scan counters are never disturbed by screen changes or blinking.
- Divider, index and blink counter are all wrap-around; no saturation.

## Test plan
- Reset: assert RESET mid-scan → `SEG_COM`=0xFF and `SEG_DATA`=0x00 immediately. After release, the first edge gives `SEG_COM`=0xFE with SCAN_DIV=1, and the index walks FE, FD, FB … 7F, FE.
- PLAY render: STATE_GAME=0110, STATE3=000, LEVEL=3, COUNT_DOWN=4, G10=3, G1=0, P10=0, P1=7 → per digit 7..0: 38, 4F, 00, 66, 4F, BF, 00, 07. `SCREEN`=2, with no blinking.
- Countdown blink: in PLAY, COUNT_DOWN=1 → digit 4 alternates 06 / 00 every 500 cycles; other digits steady.
- Priority/blink: STATE3=111 → `SCREEN`=4 within 1 cycle. Digits render "ALL CLr"; blank for counts 500..999; visible again at 1000. Switching to STATE3=010 restarts the blink counter and shows "FAIL" for 500 cycles.
- Range/OFF: LEVEL=12 in READY → digit 0 = 0x40. STATE_GAME=0101 → `SCREEN`=0 and all `SEG_DATA` 0x00 while `SEG_COM` keeps scanning.
